linear_interpolator: RTL and testbench

//  Integer-factor upsampler: the counterpart of the filtering decimator on the
//  DAC/output side of the signal chain. Takes signed AXI-stream samples at
//  the low rate and emits RATE samples per input on an AXI-stream output.

---
 rtl/linear_interpolator_if.sv | 21 ++
 rtl/linear_interpolator.sv | 115 +++++++++++
 tb/tb_linear_interpolator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/linear_interpolator_if.sv
// AXI-stream style sample bus shared by the input and output sides of the interpolator.
// Master drives data/valid, slave drives ready.
interface linear_interpolator_if #(
    parameter int unsigned DATA_PATH_WIDTH = 16
);
    logic signed [DATA_PATH_WIDTH-1:0] tdata;
    logic                              tvalid;
    logic                              tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/linear_interpolator.sv
// Integer-factor upsampler: emits RATE linearly interpolated samples per input,
// walking from the previous input up to (excluding) the current one.
module linear_interpolator #(
    parameter int unsigned DATA_PATH_WIDTH = 16,
    parameter int unsigned RATE            = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    linear_interpolator_if.slave   i_data_in,
    linear_interpolator_if.master  o_data_out
);
    localparam int unsigned DW        = DATA_PATH_WIDTH;
    localparam int unsigned RATE_LOG2 = $clog2(RATE);
    localparam int unsigned PW        = DW + 1 + RATE_LOG2;
    localparam logic [RATE_LOG2-1:0] K_LAST = RATE_LOG2'(RATE - 1);

    typedef enum logic [1:0] {
        StEmpty,
        StPrimed,
        StEmit
    } state_e;

    state_e                r_state;
    logic signed [DW-1:0]  r_prev;
    logic signed [DW-1:0]  r_curr;
    logic [RATE_LOG2-1:0]  r_k;
    logic                  r_out_valid;
    logic                  r_idle_ready;

    logic                  w_k_last;
    logic                  w_in_ready;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic signed [PW-1:0]  w_diff;
    logic signed [PW-1:0]  w_k;
    logic signed [PW-1:0]  w_prod;
    logic signed [PW-1:0]  w_step;
    logic signed [DW-1:0]  w_out;

    // Ready in EMIT only on the last beat of a segment, so the next sample
    // lands exactly as the segment retires.
    always_comb begin
        w_k_last   = (r_k == K_LAST);
        w_in_ready = r_idle_ready | (r_out_valid & w_k_last & o_data_out.tready);
        w_in_hs    = i_data_in.tvalid & w_in_ready;
        w_out_hs   = r_out_valid & o_data_out.tready;
    end

    // Arithmetic shift floors toward -inf; result always lies between prev and curr.
    always_comb begin
        w_diff = PW'(r_curr) - PW'(r_prev);
        w_k    = $signed({{(PW - RATE_LOG2){1'b0}}, r_k});
        w_prod = w_diff * w_k;
        w_step = w_prod >>> RATE_LOG2;
        w_out  = DW'(PW'(r_prev) + w_step);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StEmpty;
            r_prev       <= '0;
            r_curr       <= '0;
            r_k          <= '0;
            r_out_valid  <= 1'b0;
            r_idle_ready <= 1'b0;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    r_idle_ready <= 1'b1;
                    if (w_in_hs) begin
                        r_prev  <= i_data_in.tdata;
                        r_state <= StPrimed;
                    end
                end
                StPrimed: begin
                    if (w_in_hs) begin
                        r_curr       <= i_data_in.tdata;
                        r_k          <= '0;
                        r_out_valid  <= 1'b1;
                        r_idle_ready <= 1'b0;
                        r_state      <= StEmit;
                    end else begin
                        r_idle_ready <= 1'b1;
                    end
                end
                StEmit: begin
                    if (w_out_hs) begin
                        if (!w_k_last) begin
                            r_k <= r_k + 1'b1;
                        end else begin
                            r_prev <= r_curr;
                            if (w_in_hs) begin
                                r_curr <= i_data_in.tdata;
                                r_k    <= '0;
                            end else begin
                                r_out_valid  <= 1'b0;
                                r_idle_ready <= 1'b1;
                                r_state      <= StPrimed;
                            end
                        end
                    end
                end
                default: begin
                    r_out_valid  <= 1'b0;
                    r_idle_ready <= 1'b0;
                    r_state      <= StEmpty;
                end
            endcase
        end
    end

    assign i_data_in.tready  = w_in_ready;
    assign o_data_out.tvalid = r_out_valid;
    assign o_data_out.tdata  = w_out;
endmodule

// File: tb/tb_linear_interpolator.sv
// Directed bench for linear_interpolator (RATE=4): ramps, rounding, extremes,
// backpressure, sustained throughput and asynchronous reset mid-segment.
module tb_linear_interpolator;
    localparam int DW   = 16;
    localparam int RATE = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    linear_interpolator_if #(.DATA_PATH_WIDTH(DW)) in_if ();
    linear_interpolator_if #(.DATA_PATH_WIDTH(DW)) out_if ();

    linear_interpolator #(
        .DATA_PATH_WIDTH(DW),
        .RATE           (RATE)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_data_in (in_if),
        .o_data_out(out_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic signed [DW-1:0] q_in[$];
    logic signed [DW-1:0] q_exp[$];

    task automatic do_reset();
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        out_if.tready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Streams q_in through the DUT and compares every output beat with q_exp.
    task automatic stream(input string name, input logic [3:0] pat, input bit want_cont);
        int idx = 0;
        int oidx = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        bit seen = 1'b0;
        bit done = 1'b0;
        logic signed [DW-1:0] held = '0;
        logic exp_rdy;
        while (!done && cyc < 2000) begin
            in_if.tvalid  = (idx < q_in.size());
            in_if.tdata   = (idx < q_in.size()) ? q_in[idx] : '0;
            out_if.tready = pat[cyc % 4];
            #1;
            if (stalled) begin
                n_checks++;
                if (out_if.tvalid !== 1'b1 || out_if.tdata !== held) begin
                    n_errors++;
                    $display("FAIL %s stall_hold: got valid=%b data=%0d, need valid=1 data=%0d",
                             name, out_if.tvalid, out_if.tdata, held);
                end
            end
            exp_rdy = out_if.tvalid ? ((oidx % RATE == RATE - 1) && out_if.tready) : 1'b1;
            n_checks++;
            if (in_if.tready !== exp_rdy) begin
                n_errors++;
                $display("FAIL %s in_tready: cycle %0d got %b need %b", name, cyc,
                         in_if.tready, exp_rdy);
            end
            if (want_cont && seen && oidx < q_exp.size()) begin
                n_checks++;
                if (out_if.tvalid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s continuous_valid: output %0d got tvalid=%b need 1",
                             name, oidx, out_if.tvalid);
                end
            end
            if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
                n_checks++;
                if (oidx >= q_exp.size()) begin
                    n_errors++;
                    $display("FAIL %s extra_output: got %0d, need no output", name, out_if.tdata);
                end else if (out_if.tdata !== q_exp[oidx]) begin
                    n_errors++;
                    $display("FAIL %s out[%0d]: got %0d need %0d", name, oidx, out_if.tdata,
                             q_exp[oidx]);
                end
                oidx++;
                seen = 1'b1;
            end
            stalled = (out_if.tvalid === 1'b1) && !out_if.tready;
            held    = out_if.tdata;
            if (in_if.tvalid && in_if.tready === 1'b1) idx++;
            if (idx == q_in.size() && oidx == q_exp.size() && out_if.tvalid === 1'b0) done = 1'b1;
            cyc++;
            @(negedge clk);
        end
        in_if.tvalid = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s completion: got %0d inputs/%0d outputs, need %0d/%0d",
                     name, idx, oidx, q_in.size(), q_exp.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        out_if.tready = 1'b1;
        #2;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (out_if.tvalid !== 1'b0 || in_if.tready !== 1'b0 || out_if.tdata !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got valid=%b ready=%b data=%0d need 0/0/0",
                     out_if.tvalid, in_if.tready, out_if.tdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (out_if.tvalid !== 1'b0 || in_if.tready !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_idle: got valid=%b ready=%b need 0/1",
                     out_if.tvalid, in_if.tready);
        end
        @(negedge clk);
    endtask

    task automatic test_ramp();
        do_reset();
        q_in  = '{0, 100, 200};
        q_exp = '{0, 25, 50, 75, 100, 125, 150, 175};
        stream("ramp", 4'b1111, 1'b0);
        // No extrapolation while waiting for the next input.
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (out_if.tvalid !== 1'b0 || in_if.tready !== 1'b1) begin
                n_errors++;
                $display("FAIL primed_idle: got valid=%b ready=%b need 0/1",
                         out_if.tvalid, in_if.tready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_floor();
        do_reset();
        q_in  = '{0, -3};
        q_exp = '{0, -1, -2, -3};
        stream("floor", 4'b1111, 1'b0);
    endtask

    task automatic test_extremes();
        do_reset();
        q_in  = '{-32768, 32767};
        q_exp = '{-32768, -16385, -1, 16383};
        stream("extremes", 4'b1111, 1'b0);
    endtask

    task automatic test_backpressure();
        do_reset();
        q_in  = '{0, 100, 200};
        q_exp = '{0, 25, 50, 75, 100, 125, 150, 175};
        stream("backpressure", 4'b1001, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        q_in  = {};
        q_exp = {};
        for (int i = 0; i < 64; i++) q_in.push_back(DW'(40 * i));
        for (int n = 0; n < 252; n++) q_exp.push_back(DW'(10 * n));
        stream("throughput", 4'b1111, 1'b1);
    endtask

    task automatic test_reset_mid_emit();
        int idx = 0;
        int oidx = 0;
        bit hit = 1'b0;
        do_reset();
        q_in = '{0, 100};
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            in_if.tvalid  = (idx < q_in.size());
            in_if.tdata   = (idx < q_in.size()) ? q_in[idx] : '0;
            out_if.tready = 1'b1;
            #1;
            if (out_if.tvalid === 1'b1) oidx++;
            if (in_if.tvalid && in_if.tready === 1'b1) idx++;
            if (oidx == 2) hit = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL reset_mid_reach: got %0d outputs, need 2 before reset", oidx);
        end
        in_if.tvalid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_if.tvalid !== 1'b0 || in_if.tready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_async: got valid=%b ready=%b need 0/0",
                     out_if.tvalid, in_if.tready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        q_in  = '{500, 600};
        q_exp = '{500, 525, 550, 575};
        stream("after_reset", 4'b1111, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_floor();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
